cpu_seq_ctrl: RTL
=================

// Module: cpu_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the CPU32 datapath. Steps each instruction through
//  FETCH/DECODE/EXEC/MEM/WB and drives the PC, IR, register-file and RAM enables.
//  Sources decoded control fields from the instruction decoder's cpath output.
//  Runs req/ack handshakes to instruction and data memory, with per-access timeout.
// PARAMETERS
//  MEM_TO     16  max cycles a memory req waits for ack before an exception (>=2)
//  TO_W       8   timeout counter width; must satisfy MEM_TO <= 2**TO_W
//  EXCP_HALT  1   1: exception vectors PC then HALT; 0: vectors PC then FETCH
// PORTS
//  clk         in   1   clock; all state on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  run         in   1   level; 1 = execute instructions, 0 = stop at next retire
//  imem_req    out  1   instruction fetch request
//  imem_ack    in   1   fetch data valid this cycle
//  ir_we       out  1   latch instruction register
//  dec_reg_wr  in   1   decoded: instruction writes register file
//  dec_ram_rd  in   1   decoded: register source is RAM (load)
//  dec_ram_wr  in   1   decoded: RAM write (store)
//  dec_branch  in   1   decoded: conditional branch
//  dec_jump    in   1   decoded: jump
//  dec_excp    in   1   decoded: illegal opcode
//  br_taken    in   1   ALU branch condition, valid in EXEC
//  dmem_req    out  1   data memory request
//  dmem_we     out  1   data memory write strobe (qualifies dmem_req)
//  dmem_ack    in   1   data access complete this cycle
//  rf_we       out  1   register file write enable
//  pc_we       out  1   PC load enable
//  pc_sel      out  2   00 PC+4, 01 branch target, 10 jump target, 11 exception vector
//  retire      out  1   1-cycle pulse per completed instruction
//  excp        out  1   1-cycle pulse in EXCP state
//  halted      out  1   1 while in HALT
//  state       out  3   current state code (debug)
//  cycle_cnt   out  32  free-running cycle count (see CONFIGURATION)
//  inst_cnt    out  32  retired-instruction count (see CONFIGURATION)
// BEHAVIOUR
//  States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 EXCP=6 HALT=7. Outputs are
//   combinational from state + same-cycle inputs; only state, timeout and counters are registered.
//  Reset (async, rst_n=0): state=IDLE, timeout=0, counters=0; every output 0.
//  IDLE: all outputs 0; run=1 -> FETCH next cycle.
//  FETCH: imem_req=1 until imem_ack; ack cycle: ir_we=1, -> DECODE.
//  DECODE: one cycle; dec_excp -> EXCP, else -> EXEC. Decode inputs must be stable
//   from DECODE until the instruction retires.
//  EXEC: dec_branch: pc_we=1, pc_sel=br_taken?01:00, retire=1.
//   dec_jump: pc_we=1, pc_sel=10, retire=1.
//   dec_ram_rd|dec_ram_wr -> MEM; else -> WB.
//  MEM: dmem_req=1, dmem_we=dec_ram_wr, held until dmem_ack.
//   ack on store: pc_we=1, pc_sel=00, retire=1. ack on load -> WB.
//  WB: rf_we=dec_reg_wr, pc_we=1, pc_sel=00, retire=1.
//  Retire point (any cycle with retire=1): next state FETCH if run=1, else IDLE.
//  Timeout: counter cleared on entry to FETCH/MEM, +1 per waiting cycle.
//   After MEM_TO consecutive cycles without ack -> EXCP; the access is abandoned.
//   Ack in the last allowed cycle wins over timeout.
//  EXCP: pc_we=1, pc_sel=11, excp=1, retire=0, one cycle; then HALT if EXCP_HALT=1,
//   else FETCH (run=1) / IDLE (run=0).
//  HALT: halted=1, all other outputs 0; leaves only via reset.
//  run=0 mid-instruction: instruction completes normally, then IDLE.
//  Reset mid-access: requests drop asynchronously; no retire or rf_we is issued.
//  Exactly one of pc_sel codes per pc_we cycle; rf_we and dmem_we never both high.
// CONFIGURATION
//  CPU32_PERF_CNT_EN defined: cycle_cnt +1 every cycle state!=IDLE/HALT;
//   inst_cnt +1 per retire; both wrap 0xFFFFFFFF->0.
//  Not defined: ports still present, tied to 32'd0; no counter flops.
// TESTING
//  run=1, addi, ack 1 cycle after req -> F,D,E,WB; rf_we=1 in WB; retire 5th cycle.
//  lw, dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, then WB rf_we=1.
//  sw -> MEM dmem_we=1; retire on ack cycle; no WB, rf_we never 1.
//  beq: br_taken=1 -> EXEC pc_sel=01; br_taken=0 -> pc_sel=00; both retire, next FETCH.
//  dec_excp=1 (EXCP_HALT=1) -> EXCP pc_sel=11 excp=1, then halted=1 until rst_n=0.
//  MEM_TO=4, imem_ack never -> EXCP after 4 req cycles; ack in 4th -> DECODE instead.
//  run dropped in FETCH -> instruction retires, then IDLE; rst_n=0 in MEM clears dmem_req at once.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the CPU32 datapath with timed memory handshakes.
// Optional performance counters are built only when CPU32_PERF_CNT_EN is defined.
module cpu_seq_ctrl #(
    parameter int MEM_TO    = 16,
    parameter int TO_W      = 8,
    parameter int EXCP_HALT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_we,
    input  logic        dec_reg_wr,
    input  logic        dec_ram_rd,
    input  logic        dec_ram_wr,
    input  logic        dec_branch,
    input  logic        dec_jump,
    input  logic        dec_excp,
    input  logic        br_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        retire,
    output logic        excp,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] inst_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_EXCP   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [1:0] SEL_PC4  = 2'b00;
    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_JMP  = 2'b10;
    localparam logic [1:0] SEL_VEC  = 2'b11;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TO - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    state_t          after_retire;

    assign after_retire = run ? S_FETCH : S_IDLE;
    assign state        = state_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        to_d     = to_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = SEL_PC4;
        retire   = 1'b0;
        excp     = 1'b0;
        halted   = 1'b0;

        unique case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (to_q == TO_LAST) begin
                    state_d = S_EXCP;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_DECODE: state_d = dec_excp ? S_EXCP : S_EXEC;
            S_EXEC: begin
                if (dec_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = br_taken ? SEL_BR : SEL_PC4;
                    retire  = 1'b1;
                    state_d = after_retire;
                end else if (dec_jump) begin
                    pc_we   = 1'b1;
                    pc_sel  = SEL_JMP;
                    retire  = 1'b1;
                    state_d = after_retire;
                end else if (dec_ram_rd || dec_ram_wr) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_ram_wr;
                if (dmem_ack) begin
                    if (dec_ram_wr) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = after_retire;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = S_EXCP;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_WB: begin
                rf_we   = dec_reg_wr;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = after_retire;
            end
            S_EXCP: begin
                pc_we   = 1'b1;
                pc_sel  = SEL_VEC;
                excp    = 1'b1;
                state_d = (EXCP_HALT != 0) ? S_HALT : after_retire;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Any state change restarts the wait budget, so each FETCH/MEM entry starts at zero.
        if (state_d != state_q) to_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            to_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state_q <= state_d;
            to_q    <= to_d;
        end
    end

`ifdef CPU32_PERF_CNT_EN
    logic [31:0] cyc_q, inst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= '0;
            inst_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_HALT) cyc_q <= cyc_q + 32'd1;
            if (retire) inst_q <= inst_q + 32'd1;
        end
    end

    assign cycle_cnt = cyc_q;
    assign inst_cnt  = inst_q;
`else
    assign cycle_cnt = 32'd0;
    assign inst_cnt  = 32'd0;
`endif

endmodule
